// File: rtl/sram_like_arbiter.sv
// Round-robin arbiter merging NUM_M sram-like masters onto one slave port,
// with address-phase lock and an in-order return-routing FIFO.
//
// Ports:
//   clk, reset                   clock, async active-high reset
//   m_req/m_wr/m_size/m_wstrb    per-master request fields (packed, master 0 in LSBs)
//   m_addr/m_wdata               per-master address / write data (32b each)
//   m_addr_ok/m_data_ok          per-master accept / data-return pulses
//   m_rdata                      read data broadcast to all masters
//   s_*                          slave-side request fields and handshakes
//   ot_count                     accepted-but-not-returned transaction count
//   err_orphan                   sticky: s_data_ok seen with nothing outstanding
module sram_like_arbiter #(
    parameter int NUM_M    = 2,
    parameter int OT_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_M-1:0]            m_req,
    input  logic [NUM_M-1:0]            m_wr,
    input  logic [2*NUM_M-1:0]          m_size,
    input  logic [4*NUM_M-1:0]          m_wstrb,
    input  logic [32*NUM_M-1:0]         m_addr,
    input  logic [32*NUM_M-1:0]         m_wdata,
    output logic [NUM_M-1:0]            m_addr_ok,
    output logic [NUM_M-1:0]            m_data_ok,
    output logic [31:0]                 m_rdata,
    output logic                        s_req,
    output logic                        s_wr,
    output logic [1:0]                  s_size,
    output logic [3:0]                  s_wstrb,
    output logic [31:0]                 s_addr,
    output logic [31:0]                 s_wdata,
    input  logic                        s_addr_ok,
    input  logic                        s_data_ok,
    input  logic [31:0]                 s_rdata,
    output logic [$clog2(OT_DEPTH):0]   ot_count,
    output logic                        err_orphan
);

    localparam int IW = $clog2(NUM_M);
    localparam int PW = $clog2(OT_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   g_q, g_d;
    logic [IW-1:0]   rr_q;
    logic [IW-1:0]   winner;
    logic [IW-1:0]   sel;
    logic [IW-1:0]   idx;
    logic [IW:0]     sum;
    logic            found;
    logic            full;
    logic            hs;
    logic            pop;

    logic [IW-1:0]   fifo_mem [OT_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [IW-1:0]   head;

    // First requester at or after rr_q, wrapping past NUM_M-1 back to 0.
    always_comb begin
        winner = rr_q;
        found  = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int k = 0; k < NUM_M; k++) begin
            sum = {1'b0, rr_q} + (IW+1)'(k);
            if (sum >= (IW+1)'(NUM_M)) begin
                sum = sum - (IW+1)'(NUM_M);
            end
            idx = sum[IW-1:0];
            if (!found && m_req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign sel  = (state_q == LOCK) ? g_q : winner;
    assign full = (ot_count == CW'(OT_DEPTH));

    // No bypass when full: a same-cycle pop does not open the request path.
    assign s_req = (|m_req) & ~full & ~reset;
    assign hs    = s_req & s_addr_ok;

    // Pop uses the count before this cycle's push, so an empty FIFO
    // never returns the entry being pushed right now.
    assign pop   = s_data_ok & (ot_count != '0) & ~reset;
    assign head  = fifo_mem[rd_ptr];

    assign m_rdata = s_rdata;

    always_comb begin
        s_wr      = 1'b0;
        s_size    = '0;
        s_wstrb   = '0;
        s_addr    = '0;
        s_wdata   = '0;
        m_addr_ok = '0;
        m_data_ok = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (sel == IW'(i)) begin
                s_wr         = m_wr[i];
                s_size       = m_size[2*i +: 2];
                s_wstrb      = m_wstrb[4*i +: 4];
                s_addr       = m_addr[32*i +: 32];
                s_wdata      = m_wdata[32*i +: 32];
                m_addr_ok[i] = hs;
            end
            if (head == IW'(i)) begin
                m_data_ok[i] = pop;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        case (state_q)
            IDLE: begin
                if (s_req && !s_addr_ok) begin
                    state_d = LOCK;
                    g_d     = winner;
                end
            end
            LOCK: begin
                // Held while full; otherwise released by accept or by the
                // locked master withdrawing its request.
                if (!full && (hs || !m_req[g_q])) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            g_q     <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            if (hs) begin
                rr_q <= (sel == IW'(NUM_M - 1)) ? '0 : sel + IW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (hs) begin
            fifo_mem[wr_ptr] <= sel;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ot_count   <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (hs) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (hs && !pop) begin
                ot_count <= ot_count + CW'(1);
            end else if (pop && !hs) begin
                ot_count <= ot_count - CW'(1);
            end
            if (s_data_ok && ot_count == '0) begin
                err_orphan <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: queue-based reference model, directed
// scenarios, random traffic, plus a NUM_M=4/OT_DEPTH=8 instance.
module tb_sram_like_arbiter;

    localparam int NM  = 2;
    localparam int OT  = 4;
    localparam int NM2 = 4;
    localparam int OT2 = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [NM-1:0]        m_req;
    logic                 a_wr    [NM];
    logic [1:0]           a_size  [NM];
    logic [3:0]           a_wstrb [NM];
    logic [31:0]          a_addr  [NM];
    logic [31:0]          a_wdata [NM];
    logic [NM-1:0]        m_wr;
    logic [2*NM-1:0]      m_size;
    logic [4*NM-1:0]      m_wstrb;
    logic [32*NM-1:0]     m_addr, m_wdata;
    logic [NM-1:0]        m_addr_ok, m_data_ok;
    logic [31:0]          m_rdata;
    logic                 s_req, s_wr;
    logic [1:0]           s_size;
    logic [3:0]           s_wstrb;
    logic [31:0]          s_addr, s_wdata, s_rdata;
    logic                 s_addr_ok, s_data_ok;
    logic [$clog2(OT):0]  ot_count;
    logic                 err_orphan;

    for (genvar g = 0; g < NM; g++) begin : g_pack
        assign m_wr[g]            = a_wr[g];
        assign m_size[2*g +: 2]   = a_size[g];
        assign m_wstrb[4*g +: 4]  = a_wstrb[g];
        assign m_addr[32*g +: 32] = a_addr[g];
        assign m_wdata[32*g +: 32] = a_wdata[g];
    end

    sram_like_arbiter #(.NUM_M(NM), .OT_DEPTH(OT)) dut (
        .clk(clk), .reset(reset),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
        .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb),
        .s_addr(s_addr), .s_wdata(s_wdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
        .ot_count(ot_count), .err_orphan(err_orphan)
    );

    logic [NM2-1:0]        b_m_req;
    logic [NM2-1:0]        b_m_addr_ok, b_m_data_ok;
    logic [31:0]           b_m_rdata, b_s_addr, b_s_wdata;
    logic                  b_s_req, b_s_wr, b_s_addr_ok, b_err_orphan;
    logic [1:0]            b_s_size;
    logic [3:0]            b_s_wstrb;
    logic [$clog2(OT2):0]  b_ot_count;

    sram_like_arbiter #(.NUM_M(NM2), .OT_DEPTH(OT2)) dut_b (
        .clk(clk), .reset(reset),
        .m_req(b_m_req), .m_wr('0), .m_size('0), .m_wstrb('0),
        .m_addr({32'h400, 32'h300, 32'h200, 32'h100}), .m_wdata('0),
        .m_addr_ok(b_m_addr_ok), .m_data_ok(b_m_data_ok), .m_rdata(b_m_rdata),
        .s_req(b_s_req), .s_wr(b_s_wr), .s_size(b_s_size), .s_wstrb(b_s_wstrb),
        .s_addr(b_s_addr), .s_wdata(b_s_wdata),
        .s_addr_ok(b_s_addr_ok), .s_data_ok(1'b0), .s_rdata(32'h0),
        .ot_count(b_ot_count), .err_orphan(b_err_orphan)
    );

    // Reference model: queue of granted master indices plus grant state.
    int  q[$];
    bit  locked, orphan;
    int  gnt, rr;
    bit  e_sreq, e_hs, e_pop, e_full;
    int  e_sel;
    int  n_chk, n_fail;
    bit  pend [NM];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic mreset();
        q.delete();
        locked = 0;
        orphan = 0;
        gnt    = 0;
        rr     = 0;
    endtask

    task automatic drv(input logic [NM-1:0] rq, input bit aok,
                       input bit dok, input logic [31:0] rd);
        m_req     = rq;
        s_addr_ok = aok;
        s_data_ok = dok;
        s_rdata   = rd;
    endtask

    task automatic settle();
        bit found;
        int i;
        #1;
        e_full = (q.size() == OT);
        e_sreq = (m_req != '0) && !e_full;
        e_sel  = locked ? gnt : rr;
        found  = locked;
        for (int k = 0; k < NM; k++) begin
            i = (rr + k) % NM;
            if (!found && ((m_req >> i) & 1'b1) != 0) begin
                e_sel = i;
                found = 1;
            end
        end
        e_hs  = e_sreq && s_addr_ok;
        e_pop = s_data_ok && q.size() > 0;
        chk("s_req", 32'(s_req), 32'(e_sreq));
        chk("m_addr_ok", 32'(m_addr_ok), e_hs ? (1 << e_sel) : 0);
        chk("m_data_ok", 32'(m_data_ok), e_pop ? (1 << q[0]) : 0);
        chk("ot_count", 32'(ot_count), q.size());
        chk("err_orphan", 32'(err_orphan), 32'(orphan));
        if (e_sreq) begin
            chk("s_addr", s_addr, a_addr[e_sel]);
            chk("s_wdata", s_wdata, a_wdata[e_sel]);
            chk("s_ctl", 32'({s_wr, s_size, s_wstrb}),
                32'({a_wr[e_sel], a_size[e_sel], a_wstrb[e_sel]}));
        end
        if (e_pop) chk("m_rdata", m_rdata, s_rdata);
    endtask

    task automatic adv();
        @(posedge clk);
        if (e_pop) void'(q.pop_front());
        else if (s_data_ok) orphan = 1;
        if (e_hs) begin
            q.push_back(e_sel);
            rr = (e_sel + 1) % NM;
        end
        if (!e_full) begin
            if (!locked && e_sreq && !s_addr_ok) begin
                locked = 1;
                gnt    = e_sel;
            end else if (locked && (e_hs || ((m_req >> gnt) & 1'b1) == 0)) begin
                locked = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic tick();
        settle();
        adv();
    endtask

    task automatic drain();
        drv('0, 0, 1, 32'hD00D);
        for (int k = 0; k < OT + 2; k++) begin
            if (q.size() == 0) break;
            tick();
        end
        drv('0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;
        for (int i = 0; i < NM; i++) begin
            a_addr[i]  = 32'h100 * (i + 1);
            a_wdata[i] = 32'hD0 + i;
            a_wr[i]    = 1'(i);
            a_size[i]  = 2'(i + 1);
            a_wstrb[i] = 4'(3 << i);
            pend[i]    = 0;
        end
        b_m_req     = '0;
        b_s_addr_ok = 1'b0;
        reset       = 1'b1;
        mreset();
        drv('1, 1, 1, 0);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_s_req", 32'(s_req), 0);
        chk("rst_addr_ok", 32'(m_addr_ok), 0);
        chk("rst_data_ok", 32'(m_data_ok), 0);
        chk("rst_ot_count", 32'(ot_count), 0);
        chk("rst_orphan", 32'(err_orphan), 0);
        @(negedge clk);
        reset = 1'b0;
        drv('0, 0, 0, 0);

        // Back-to-back: grants alternate 0,1,0,1
        for (int k = 0; k < 4; k++) begin
            drv(2'b11, 1, 0, 0);
            settle();
            chk("b2b_grant", 32'(m_addr_ok), (k % 2) ? 2 : 1);
            adv();
        end
        drain();

        // Lock: rr points at m1, but m0 holds the locked grant
        drv(2'b01, 1, 0, 0);
        tick();
        for (int k = 1; k <= 4; k++) begin
            drv((k == 1) ? 2'b01 : 2'b11, (k == 4), 0, 0);
            settle();
            chk("lock_addr", s_addr, 32'h100);
            if (k == 4) chk("lock_acc", 32'(m_addr_ok), 1);
            adv();
        end
        drv(2'b10, 1, 0, 0);
        tick();
        drain();

        // Full: four accepts, no bypass on the popping cycle
        drv(2'b10, 1, 0, 0);
        tick();
        repeat (3) begin
            drv(2'b01, 1, 0, 0);
            tick();
        end
        drv(2'b01, 1, 0, 0);
        settle();
        chk("full_cnt", 32'(ot_count), 4);
        chk("full_sreq", 32'(s_req), 0);
        adv();
        drv(2'b01, 1, 1, 32'h55);
        settle();
        chk("full_pop", 32'(m_data_ok), 2);
        chk("full_nobypass", 32'(s_req), 0);
        adv();
        drv(2'b01, 1, 0, 0);
        settle();
        chk("full_cnt3", 32'(ot_count), 3);
        chk("full_sreq1", 32'(s_req), 1);
        adv();
        drain();

        // Ordering: m1,m0,m1 returned in order
        drv(2'b10, 1, 0, 0); tick();
        drv(2'b01, 1, 0, 0); tick();
        drv(2'b10, 1, 0, 0); tick();
        for (int k = 0; k < 3; k++) begin
            drv('0, 0, 1, 32'hA + k);
            settle();
            chk("ord_dok", 32'(m_data_ok), (k == 1) ? 1 : 2);
            chk("ord_rdata", m_rdata, 32'hA + k);
            adv();
        end

        // Simultaneous push and pop at count 2
        drv(2'b01, 1, 0, 0); tick();
        drv(2'b10, 1, 0, 0); tick();
        drv(2'b01, 1, 1, 32'h77);
        settle();
        chk("pp_oldest", 32'(m_data_ok), 1);
        adv();
        drv('0, 0, 0, 0);
        settle();
        chk("pp_cnt", 32'(ot_count), 2);
        adv();
        drain();

        // Orphan with empty FIFO
        drv('0, 0, 1, 32'h99);
        settle();
        chk("orph_dok", 32'(m_data_ok), 0);
        adv();
        drv('0, 0, 0, 0);
        settle();
        chk("orph_flag", 32'(err_orphan), 1);
        adv();

        // Reset mid-burst with three outstanding
        repeat (3) begin
            drv(2'b01, 1, 0, 0);
            tick();
        end
        drv(2'b11, 1, 1, 0);
        #3;
        reset = 1'b1;
        #1;
        chk("mrst_s_req", 32'(s_req), 0);
        chk("mrst_addr_ok", 32'(m_addr_ok), 0);
        chk("mrst_data_ok", 32'(m_data_ok), 0);
        chk("mrst_cnt", 32'(ot_count), 0);
        chk("mrst_orphan", 32'(err_orphan), 0);
        mreset();
        @(negedge clk);
        reset = 1'b0;
        drv('0, 0, 1, 32'h1);
        settle();
        chk("post_rst_dok", 32'(m_data_ok), 0);
        adv();
        drv('0, 0, 0, 0);
        settle();
        chk("post_rst_orph", 32'(err_orphan), 1);
        adv();

        // Random traffic; masters hold request and fields until accepted
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NM; i++) begin
                if (!pend[i] && $urandom_range(1, 0) == 1) begin
                    pend[i]    = 1;
                    a_addr[i]  = $urandom;
                    a_wdata[i] = $urandom;
                    a_wr[i]    = 1'($urandom);
                    a_size[i]  = 2'($urandom);
                    a_wstrb[i] = 4'($urandom);
                end
                m_req[i] = pend[i];
            end
            s_addr_ok = ($urandom % 3) != 0;
            s_data_ok = ($urandom % 3) == 0;
            s_rdata   = $urandom;
            settle();
            for (int i = 0; i < NM; i++) begin
                if (e_hs && e_sel == i) pend[i] = 0;
            end
            adv();
        end
        drv('0, 0, 0, 0);

        // Four masters, eight deep: round-robin 0..3 and count reaches 8
        b_m_req     = '1;
        b_s_addr_ok = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("b_rr", 32'(b_m_addr_ok), 1 << (k % 4));
            chk("b_cnt", 32'(b_ot_count), k);
            @(negedge clk);
        end
        #1;
        chk("b_full_cnt", 32'(b_ot_count), 8);
        chk("b_full_sreq", 32'(b_s_req), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_like_arbiter.md
SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

Interface
REQ-001 SHALL have parameter NUM_M, default 2, meaning the number of sram-like masters (range 2..8).
REQ-002 SHALL have parameter OT_DEPTH, default 4, meaning the maximum outstanding accepted-but-not-returned transactions (power of two, 2..16).
REQ-003 SHALL have ports in this order, clock and reset first:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- m_req  in  NUM_M  per-master request.
- m_wr  in  NUM_M  per-master write flag.
- m_size  in  2*NUM_M  per-master size.
- m_wstrb  in  4*NUM_M  per-master byte strobes.
- m_addr  in  32*NUM_M  per-master address.
- m_wdata  in  32*NUM_M  per-master write data.
- m_addr_ok  out  NUM_M  per-master address accept.
- m_data_ok  out  NUM_M  per-master data return.
- m_rdata  out  32  read data, broadcast to all masters.
- s_req  out  1  slave request.
- s_wr  out  1  slave write flag.
- s_size  out  2  slave size.
- s_wstrb  out  4  slave byte strobes.
- s_addr  out  32  slave address.
- s_wdata  out  32  slave write data.
- s_addr_ok  in  1  slave address accept.
- s_data_ok  in  1  slave data return.
- s_rdata  in  32  slave read data.
- ot_count  out  clog2(OT_DEPTH)+1  number of outstanding transactions.
- err_orphan  out  1  sticky flag: s_data_ok arrived with no outstanding transaction.

Function
REQ-004 SHALL keep a two-state grant FSM, IDLE and LOCK, plus a registered grant index g_q and a round-robin pointer rr_q.
REQ-005 In IDLE, the winner SHALL be the first requesting master at or after rr_q, searched in index order with wrap-around to 0; this is combinational in the same cycle.
REQ-006 s_req SHALL be 1 only when all of the following hold:
- some m_req is 1;
- ot_count < OT_DEPTH;
- reset is low.
REQ-007 s_wr, s_size, s_wstrb, s_addr and s_wdata SHALL be a mux of the selected master's fields: the IDLE winner in IDLE, g_q in LOCK.
REQ-008 Handshake = s_req & s_addr_ok. m_addr_ok[sel] SHALL equal the handshake in the same cycle (zero latency); all other m_addr_ok bits SHALL be 0.
REQ-009 IDLE -> LOCK SHALL occur when s_req=1 and s_addr_ok=0; in that case g_q latches the winner.
REQ-010 While in LOCK, the grant SHALL NOT change, even if a master with higher round-robin priority raises m_req.
REQ-011 LOCK -> IDLE SHALL occur on a handshake, or if m_req[g_q] drops (the protocol-violating master releases the lock).
REQ-012 On every handshake, rr_q SHALL become (sel+1) mod NUM_M; otherwise rr_q holds.
REQ-013 On every handshake, sel SHALL be pushed into an in-order FIFO of depth OT_DEPTH.
REQ-014 On s_data_ok with FIFO non-empty:
- the FIFO head SHALL be popped;
- m_data_ok[head] SHALL be 1 in the same cycle and all other bits 0;
- m_rdata SHALL equal s_rdata.
REQ-015 Push and pop in the same cycle SHALL leave ot_count unchanged. Pop SHALL read the old head, so that with count=0 a same-cycle push is not popped.
REQ-016 When full (ot_count=OT_DEPTH), s_req SHALL be 0 even if a pop occurs in the same cycle (no bypass). The FSM SHALL hold its state and g_q.
REQ-017 On s_data_ok with FIFO empty:
- no m_data_ok bit SHALL assert;
- err_orphan SHALL be set and stay 1 until reset;
- ot_count SHALL stay 0.
REQ-018 FIFO read and write pointers SHALL wrap modulo OT_DEPTH.
REQ-019 ot_count SHALL equal pushes minus pops since reset, and SHALL never exceed OT_DEPTH or go below 0.

Reset
REQ-020 While reset=1, regardless of clk, the block SHALL hold:
- state=IDLE, g_q=0, rr_q=0;
- FIFO empty, ot_count=0, err_orphan=0;
- s_req=0, m_addr_ok=0, m_data_ok=0.
REQ-021 Reset asserted mid-transaction SHALL discard all outstanding entries. s_data_ok arriving after reset release for a discarded entry SHALL set err_orphan.

Verification
REQ-022 The bench SHALL cover these directed scenarios (NUM_M=2, OT_DEPTH=4 unless stated):
- Back-to-back requests: m_req=2'b11 every cycle, s_addr_ok=1 -> grants alternate 0,1,0,1; each m_addr_ok pulse lasts 1 cycle.
- Lock: m0 requests with s_addr_ok=0 for 3 cycles, m1 raises req in cycle 2 -> s_addr stays m0's address throughout; m0 is accepted in cycle 4 when s_addr_ok=1.
- Full: 4 reads accepted with no s_data_ok -> ot_count=4 and s_req=0. Then one s_data_ok -> m_data_ok for the first master, ot_count=3, and s_req=1 in the next cycle.
- Ordering: accepts in order m1,m0,m1, then three s_data_ok pulses with rdata 0xA,0xB,0xC -> m_data_ok sequence 2'b10,2'b01,2'b10 with matching m_rdata.
- Simultaneous push and pop: ot_count=2, handshake and s_data_ok in the same cycle -> ot_count stays 2 and the popped entry is the oldest.
- Orphan and reset: s_data_ok with ot_count=0 -> err_orphan=1 and no m_data_ok. Assert reset mid-burst with ot_count=3 -> all outputs 0 immediately, without waiting for a clock edge.
- Parameterisation: NUM_M=4, OT_DEPTH=8 -> round-robin visits 0..3 in order with all m_req high, and ot_count reaches 8.
